frame_arbiter: RTL and testbench
================================

FRAME_ARBITER -- requirements
Module: frame_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one framing encoder.
REQ-002 Parameter MAX_BYTES, default 20, maximum bytes per frame (encoder queue depth).
REQ-003 Parameter RIGHT_PAD, default 16, encoder right-padding length in cycles.
REQ-004 Parameter TIMEOUT, default 1023, watchdog limit in cycles; counter 10 bits.
REQ-005 clk  input  1  clock, rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  N_REQ  per-requester byte valid; doubles as frame request.
REQ-008 req_data  input  8*N_REQ  per-requester byte; requester i on bits [8i+7:8i].
REQ-009 req_last  input  N_REQ  marks final byte of requester's frame.
REQ-010 req_ready  output  N_REQ  byte accepted when req_valid[i] & req_ready[i].
REQ-011 grant  output  N_REQ  one-hot owner of encoder, zero when idle.
REQ-012 fr_din  output  8  byte to encoder din.
REQ-013 fr_din_valid  output  1  to encoder din_valid.
REQ-014 fr_indicator  input  1  encoder indicator pulse (padding-phase start).
REQ-015 busy  output  1  high whenever state != IDLE.
REQ-016 err_trunc, err_abort, err_timeout  output  1 each  single-cycle error pulses.

Function
REQ-017 States SHALL be IDLE, STREAM, WAIT_LP, WAIT_RP, DRAIN.
REQ-018 IDLE: if any req_valid, round-robin pick starting at index ptr, register one-hot grant, go STREAM next cycle; ptr becomes winner+1 mod N_REQ.
REQ-019 STREAM: req_ready = grant, except low after the MAX_BYTES-th accept.
REQ-020 Each accepted byte SHALL appear on fr_din with fr_din_valid high exactly 1 cycle later; fr_din_valid otherwise 0, fr_din 0.
REQ-021 Requesters hold req_valid until accepted; arbiter delivers bytes on consecutive cycles only, no gaps inside a frame.
REQ-022 STREAM exits to WAIT_LP on: accept with req_last; accept of byte MAX_BYTES without last (pulse err_trunc); req_valid low from granted requester (pulse err_abort, frame closes with bytes sent).
REQ-023 Truncated remainder SHALL be handled as a fresh request in later arbitration.
REQ-024 grant SHALL stay asserted through WAIT_LP, WAIT_RP, DRAIN; clears on return to IDLE.
REQ-025 WAIT_LP: first fr_indicator pulse -> WAIT_RP; WAIT_RP: next pulse -> DRAIN.
REQ-026 DRAIN: count RIGHT_PAD cycles including pulse cycle; IDLE on the cycle after, so new fr_din_valid no earlier than pulse+RIGHT_PAD+1.
REQ-027 fr_indicator SHALL be ignored in IDLE, STREAM, DRAIN.
REQ-028 Watchdog counts cycles in WAIT_LP+WAIT_RP; reaching TIMEOUT -> IDLE, err_timeout pulse, grant cleared.
REQ-029 byte counter width ceil(log2(MAX_BYTES+1)); cleared on STREAM entry.
REQ-030 Requesters not granted SHALL see req_ready 0 at all times.

Reset
REQ-031 reset_n low SHALL asynchronously force IDLE, ptr 0, all counters 0, and every output 0 (grant, req_ready, fr_din, fr_din_valid, busy, error pulses).
REQ-032 Reset mid-frame SHALL abandon the frame without error pulses; encoder reset concurrently by system.

Structure
REQ-033 framing_pkg SHALL hold state encodings, MAX_BYTES, LEFT_PAD (80), RIGHT_PAD, TIMEOUT, shared with encoder.
REQ-034 Sub-module rr_pick: combinational round-robin one-hot picker (req vector, ptr -> grant).

Verification
REQ-035 Req0 sends A1,A2,A3(last) -> fr_din A1,A2,A3 consecutive, 1 cycle after accepts; busy drops 17 cycles after second indicator.
REQ-036 All four req_valid high after reset -> grants 0,1,2,3 in order; second round restarts at 0.
REQ-037 Req2 sends 25 bytes, no last before byte 25 -> 20 bytes forwarded, err_trunc pulse, req_ready low for byte 21; remaining 5 sent as later frame.
REQ-038 Req1 drops req_valid after 2 bytes -> err_abort, 2-byte frame, WAIT_LP entered.
REQ-039 No fr_indicator after stream -> err_timeout at 1023 cycles, IDLE, grant 0.
REQ-040 reset_n low mid-STREAM -> all outputs 0 immediately; after release req3 wins first request with ptr 0.

Source files
------------

// File: rtl/framing_pkg.sv
// Shared framing constants and arbiter state encoding, common to the arbiter and the encoder.
package framing_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStream = 3'd1,
      StWaitLp = 3'd2,
      StWaitRp = 3'd3,
      StDrain  = 3'd4
   } fr_state_e;

   localparam int unsigned FR_MAX_BYTES = 20;   // encoder queue depth, bytes per frame
   localparam int unsigned FR_LEFT_PAD  = 80;   // encoder left-padding length in cycles
   localparam int unsigned FR_RIGHT_PAD = 16;   // encoder right-padding length in cycles
   localparam int unsigned FR_TIMEOUT   = 1023; // watchdog limit in cycles
   localparam int unsigned FR_WD_W      = 10;   // watchdog counter width

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [PTR_W-1:0] idx
);

   int unsigned      cand;
   logic [PTR_W-1:0] cand_idx;
   logic             found;

   // Scan requesters starting at ptr; the first hit wins.
   always_comb begin
      gnt      = '0;
      idx      = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned off = 0; off < N_REQ; off++) begin
         cand     = (32'(ptr) + off) % N_REQ;
         cand_idx = PTR_W'(cand);
         if (!found && req[cand_idx]) begin
            found         = 1'b1;
            gnt[cand_idx] = 1'b1;
            idx           = cand_idx;
         end
      end
   end

endmodule

// File: rtl/frame_arbiter.sv
// Shares one framing encoder between N_REQ byte-stream requesters, one frame at a time.
module frame_arbiter
   import framing_pkg::*;
#(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned MAX_BYTES = FR_MAX_BYTES,
   parameter int unsigned RIGHT_PAD = FR_RIGHT_PAD,
   parameter int unsigned TIMEOUT   = FR_TIMEOUT
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic [N_REQ-1:0]   grant,
   output logic [7:0]         fr_din,
   output logic               fr_din_valid,
   input  logic               fr_indicator,
   output logic               busy,
   output logic               err_trunc,
   output logic               err_abort,
   output logic               err_timeout
);

   localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned BC_W  = $clog2(MAX_BYTES + 1);
   localparam int unsigned DR_W  = $clog2(RIGHT_PAD + 1);
   localparam logic [FR_WD_W-1:0] WD_LIMIT = FR_WD_W'(TIMEOUT - 1);

   fr_state_e          state_q, state_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [BC_W-1:0]    byte_cnt_q, byte_cnt_d;
   logic [FR_WD_W-1:0] wd_q, wd_d;
   logic [DR_W-1:0]    drain_cnt_q, drain_cnt_d;
   logic [7:0]         fr_din_q, fr_din_d;
   logic               fr_din_valid_q, fr_din_valid_d;
   logic               err_trunc_q, err_trunc_d;
   logic               err_abort_q, err_abort_d;
   logic               err_timeout_q, err_timeout_d;

   logic [N_REQ-1:0]   pick_gnt;
   logic [PTR_W-1:0]   pick_idx;
   logic [7:0]         sel_data;
   logic               sel_valid;
   logic               sel_last;
   logic               accept;

   rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req (req_valid),
      .ptr (ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx)
   );

   // Mux the granted requester's byte, valid and last.
   always_comb begin
      sel_data = 8'h00;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_q[i]) begin
            sel_data = req_data[8*i +: 8];
         end
      end
      sel_valid = |(req_valid & grant_q);
      sel_last  = |(req_last & grant_q);
      accept    = |(req_valid & req_ready);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= StIdle;
         grant_q        <= '0;
         ptr_q          <= '0;
         byte_cnt_q     <= '0;
         wd_q           <= '0;
         drain_cnt_q    <= '0;
         fr_din_q       <= 8'h00;
         fr_din_valid_q <= 1'b0;
         err_trunc_q    <= 1'b0;
         err_abort_q    <= 1'b0;
         err_timeout_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         grant_q        <= grant_d;
         ptr_q          <= ptr_d;
         byte_cnt_q     <= byte_cnt_d;
         wd_q           <= wd_d;
         drain_cnt_q    <= drain_cnt_d;
         fr_din_q       <= fr_din_d;
         fr_din_valid_q <= fr_din_valid_d;
         err_trunc_q    <= err_trunc_d;
         err_abort_q    <= err_abort_d;
         err_timeout_q  <= err_timeout_d;
      end
   end

   // Next-state logic: arbitration, streaming, indicator tracking, watchdog, drain.
   always_comb begin
      state_d        = state_q;
      grant_d        = grant_q;
      ptr_d          = ptr_q;
      byte_cnt_d     = byte_cnt_q;
      wd_d           = wd_q;
      drain_cnt_d    = drain_cnt_q;
      fr_din_d       = 8'h00;
      fr_din_valid_d = 1'b0;
      err_trunc_d    = 1'b0;
      err_abort_d    = 1'b0;
      err_timeout_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (|req_valid) begin
               state_d    = StStream;
               grant_d    = pick_gnt;
               ptr_d      = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
               byte_cnt_d = '0;
            end
         end
         StStream: begin
            if (accept) begin
               fr_din_d       = sel_data;
               fr_din_valid_d = 1'b1;
               byte_cnt_d     = byte_cnt_q + BC_W'(1);
               if (sel_last) begin
                  state_d = StWaitLp;
                  wd_d    = '0;
               end else if (byte_cnt_q == BC_W'(MAX_BYTES - 1)) begin
                  // Encoder queue full: close the frame; the rest becomes a new request.
                  state_d     = StWaitLp;
                  wd_d        = '0;
                  err_trunc_d = 1'b1;
               end
            end else if (!sel_valid) begin
               // Owner went quiet mid-frame: close with what was sent.
               state_d     = StWaitLp;
               wd_d        = '0;
               err_abort_d = 1'b1;
            end
         end
         StWaitLp, StWaitRp: begin
            wd_d = wd_q + FR_WD_W'(1);
            if (fr_indicator) begin
               if (state_q == StWaitLp) begin
                  state_d = StWaitRp;
               end else begin
                  state_d     = StDrain;
                  drain_cnt_d = '0;
               end
            end else if (wd_q >= WD_LIMIT) begin
               state_d       = StIdle;
               grant_d       = '0;
               err_timeout_d = 1'b1;
            end
         end
         StDrain: begin
            // Hold off until the encoder's right padding has fully elapsed.
            if (drain_cnt_q == DR_W'(RIGHT_PAD - 1)) begin
               state_d = StIdle;
               grant_d = '0;
            end else begin
               drain_cnt_d = drain_cnt_q + DR_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
            grant_d = '0;
         end
      endcase
   end

   // Outputs decoded from state plus registered datapath.
   always_comb begin
      req_ready = '0;
      if (state_q == StStream && byte_cnt_q != BC_W'(MAX_BYTES)) begin
         req_ready = grant_q;
      end
      busy         = (state_q != StIdle);
      grant        = grant_q;
      fr_din       = fr_din_q;
      fr_din_valid = fr_din_valid_q;
      err_trunc    = err_trunc_q;
      err_abort    = err_abort_q;
      err_timeout  = err_timeout_q;
   end

endmodule

// File: tb/tb_frame_arbiter.sv
// Randomized bench for frame_arbiter against a timestamp-based frame-level reference model.
module tb_frame_arbiter;

   localparam int N  = 4;
   localparam int MB = 20;
   localparam int RP = 16;
   localparam int TO = 1023;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0]   req_last = '0;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   grant;
   logic [7:0]     fr_din;
   logic           fr_din_valid;
   logic           fr_indicator = 1'b0;
   logic           busy;
   logic           err_trunc, err_abort, err_timeout;

   always #5 clk = ~clk;

   frame_arbiter #(
      .N_REQ     (N),
      .MAX_BYTES (MB),
      .RIGHT_PAD (RP),
      .TIMEOUT   (TO)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .grant        (grant),
      .fr_din       (fr_din),
      .fr_din_valid (fr_din_valid),
      .fr_indicator (fr_indicator),
      .busy         (busy),
      .err_trunc    (err_trunc),
      .err_abort    (err_abort),
      .err_timeout  (err_timeout)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Requester side: per-requester byte queues, bit 8 = last.
   logic [8:0] rq [N][$];
   int         abort_k [N];
   int         ind_pct = 0;

   // Reference model: owner, bytes sent, indicator pulses and event timestamps.
   int     m_owner, m_ptr, m_sent, m_pulses;
   bit     m_stream;
   longint m_cyc, m_t_ws, m_t_p2;
   logic [N-1:0] e_grant, e_ready;
   logic         e_busy, e_dv, e_tr, e_ab, e_to;
   logic [7:0]   e_din;

   task automatic model_reset();
      m_owner = -1; m_ptr = 0; m_sent = 0; m_pulses = 0; m_stream = 0;
      m_cyc = 0; m_t_ws = 0; m_t_p2 = 0;
      e_grant = '0; e_ready = '0; e_busy = 0; e_dv = 0; e_tr = 0; e_ab = 0; e_to = 0;
      e_din = 8'h00;
   endtask

   task automatic model_step();
      bit found;
      m_cyc++;
      e_dv = 0; e_din = 8'h00; e_tr = 0; e_ab = 0; e_to = 0;
      if (m_owner < 0) begin
         if (req_valid != '0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
               int c;
               c = (m_ptr + k) % N;
               if (!found && req_valid[c]) begin
                  found   = 1;
                  m_owner = c;
               end
            end
            m_ptr = (m_owner + 1) % N;
            m_sent = 0; m_stream = 1; m_pulses = 0;
         end
      end else if (m_stream) begin
         if (req_valid[m_owner]) begin
            e_dv  = 1;
            e_din = req_data[8*m_owner +: 8];
            m_sent++;
            void'(rq[m_owner].pop_front());
            if (req_last[m_owner]) begin
               m_stream = 0; m_t_ws = m_cyc;
            end else if (m_sent == MB) begin
               e_tr = 1; m_stream = 0; m_t_ws = m_cyc;
            end
         end else begin
            e_ab = 1; m_stream = 0; m_t_ws = m_cyc;
         end
      end else if (m_pulses < 2) begin
         if (fr_indicator) begin
            m_pulses++;
            if (m_pulses == 2) m_t_p2 = m_cyc;
         end else if (m_cyc - m_t_ws >= TO) begin
            m_owner = -1; e_to = 1;
         end
      end else if (m_cyc - m_t_p2 >= RP) begin
         m_owner = -1;
      end
      e_grant = '0;
      if (m_owner >= 0) e_grant[m_owner] = 1'b1;
      e_ready = m_stream ? e_grant : '0;
      e_busy  = (m_owner >= 0);
   endtask

   task automatic push_frame(input int i, input int len);
      for (int b = 0; b < len; b++) begin
         logic [8:0] w;
         w[7:0] = 8'($urandom_range(0, 255));
         w[8]   = (b == len - 1);
         rq[i].push_back(w);
      end
   endtask

   task automatic drive();
      logic [N-1:0] hold;
      hold = '0;
      for (int i = 0; i < N; i++) begin
         if (m_owner == i && m_stream && abort_k[i] > 0 && m_sent == abort_k[i]
             && rq[i].size() > 0) begin
            bit done;
            done = 0;
            while (!done && rq[i].size() > 0) begin
               logic [8:0] w;
               w = rq[i].pop_front();
               done = w[8];
            end
            abort_k[i] = 0;
            hold[i]    = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         req_valid[i]       = 1'b0;
         req_last[i]        = 1'b0;
         req_data[8*i +: 8] = 8'h00;
         if (!hold[i] && rq[i].size() > 0) begin
            req_valid[i]       = 1'b1;
            req_data[8*i +: 8] = rq[i][0][7:0];
            req_last[i]        = rq[i][0][8];
         end
      end
      fr_indicator = ($urandom_range(0, 99) < ind_pct);
   endtask

   task automatic compare_all(input string pfx);
      check({pfx, "grant"}, 32'(grant), 32'(e_grant));
      check({pfx, "req_ready"}, 32'(req_ready), 32'(e_ready));
      check({pfx, "busy"}, 32'(busy), 32'(e_busy));
      check({pfx, "fr_din_valid"}, 32'(fr_din_valid), 32'(e_dv));
      check({pfx, "fr_din"}, 32'(fr_din), 32'(e_din));
      check({pfx, "err_trunc"}, 32'(err_trunc), 32'(e_tr));
      check({pfx, "err_abort"}, 32'(err_abort), 32'(e_ab));
      check({pfx, "err_timeout"}, 32'(err_timeout), 32'(e_to));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      compare_all("");
      drive();
   endtask

   task automatic run(input int n);
      drive();
      for (int k = 0; k < n; k++) cycle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout reached");
      $fatal(1, "bench watchdog");
   end

   initial begin
      bit hit;
      for (int i = 0; i < N; i++) abort_k[i] = 0;
      model_reset();
      #12;
      compare_all("reset_");
      @(negedge clk);
      reset_n = 1'b1;

      // Short frame from requester 0.
      rq[0].push_back({1'b0, 8'hA1});
      rq[0].push_back({1'b0, 8'hA2});
      rq[0].push_back({1'b1, 8'hA3});
      ind_pct = 20;
      run(80);

      // All four contend, two rounds.
      for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push_frame(i, 2);
      run(350);

      // Over-long frame gets truncated; remainder follows as its own frame.
      push_frame(2, 25);
      run(150);

      // Requester 1 drops valid after two bytes.
      abort_k[1] = 2;
      push_frame(1, 6);
      run(100);

      // No indicator at all: watchdog expires.
      ind_pct = 0;
      push_frame(0, 3);
      run(1100);
      ind_pct = 20;

      // Reset in the middle of a stream.
      push_frame(1, 10);
      drive();
      hit = 0;
      for (int k = 0; k < 200 && !hit; k++) begin
         cycle();
         if (m_stream && m_sent >= 2) hit = 1;
      end
      check("rst_reach_stream", 32'(hit), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      compare_all("rst_mid_");
      for (int i = 0; i < N; i++) begin
         rq[i].delete();
         abort_k[i] = 0;
      end
      @(negedge clk);
      reset_n = 1'b1;
      push_frame(3, 2);
      drive();
      cycle();
      check("rst_req3_grant", 32'(grant), 32'h8);
      run(60);

      // Random traffic.
      ind_pct = 25;
      drive();
      for (int k = 0; k < 2500; k++) begin
         cycle();
         if ($urandom_range(0, 9) == 0) begin
            int i;
            i = $urandom_range(0, N - 1);
            if (rq[i].size() < 40) begin
               push_frame(i, ($urandom_range(0, 7) == 0) ? $urandom_range(21, 26)
                                                         : $urandom_range(1, 6));
               if ($urandom_range(0, 5) == 0) abort_k[i] = $urandom_range(1, 4);
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
